// File: rtl/kv_req_arbiter.sv
// Round-robin arbiter sharing one key-value DB lookup port between two parser channels.
// Optional statistics counters are enabled with `define KV_ARB_STATS_EN.
module kv_req_arbiter #(
    parameter int KEY_SIZE  = 96,
    parameter int FLAG_SIZE = 4,
    parameter int REQ_DEPTH = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic                 clk156,
    input  logic                 eth_rst,
    input  logic [KEY_SIZE-1:0]  req0_key,
    input  logic [FLAG_SIZE-1:0] req0_flag,
    input  logic                 req0_valid,
    input  logic [KEY_SIZE-1:0]  req1_key,
    input  logic [FLAG_SIZE-1:0] req1_flag,
    input  logic                 req1_valid,
    output logic [KEY_SIZE-1:0]  db_key,
    output logic [FLAG_SIZE-1:0] db_flag,
    output logic                 db_valid,
    input  logic                 db_ready,
    input  logic                 db_rsp_valid,
    input  logic [FLAG_SIZE-1:0] db_rsp_flag,
    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [FLAG_SIZE-1:0] rsp_flag,
    output logic [1:0]           drop,
    output logic                 err_unexp
`ifdef KV_ARB_STATS_EN
    ,
    output logic [31:0]          stat_grant0,
    output logic [31:0]          stat_grant1,
    output logic [31:0]          stat_drop0,
    output logic [31:0]          stat_drop1
`endif
);

    localparam int ENT_W = KEY_SIZE + FLAG_SIZE;
    localparam int RA    = $clog2(REQ_DEPTH);
    localparam int TA    = $clog2(MAX_OUTST);
    localparam logic [RA:0] REQ_FULL = (RA+1)'(REQ_DEPTH);
    localparam logic [TA:0] OUT_MAX  = (TA+1)'(MAX_OUTST);

    logic [ENT_W-1:0] fifo_mem [2][REQ_DEPTH];
    logic [ENT_W-1:0] req_ent  [2];
    logic [RA-1:0]    wr_ptr_q [2];
    logic [RA-1:0]    wr_ptr_d [2];
    logic [RA-1:0]    rd_ptr_q [2];
    logic [RA-1:0]    rd_ptr_d [2];
    logic [RA:0]      cnt_q    [2];
    logic [RA:0]      cnt_d    [2];

    logic [1:0] req_v, push, pop, nonempty, full, drop_d, drop_q;
    logic       last_q, last_d, grant, issue, slot_free;

    logic                 db_valid_q, db_valid_d;
    logic [KEY_SIZE-1:0]  db_key_q, db_key_d;
    logic [FLAG_SIZE-1:0] db_flag_q, db_flag_d;

    logic          tag_mem [MAX_OUTST];
    logic [TA-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [TA:0]   tag_cnt_q, tag_cnt_d;
    logic          tag_pop, unexp;

    logic                 rsp0_q, rsp0_d, rsp1_q, rsp1_d, err_q, err_d;
    logic [FLAG_SIZE-1:0] rsp_flag_q, rsp_flag_d;

    assign req_v      = {req1_valid, req0_valid};
    assign req_ent[0] = {req0_key, req0_flag};
    assign req_ent[1] = {req1_key, req1_flag};

    always_comb begin
        nonempty = '0;
        full     = '0;
        push     = '0;
        drop_d   = '0;
        for (int c = 0; c < 2; c++) begin
            nonempty[c] = (cnt_q[c] != '0);
            full[c]     = (cnt_q[c] == REQ_FULL);
        end

        slot_free = !db_valid_q || db_ready;
        // Contention goes to the channel not served last; a lone requester always wins.
        grant  = (nonempty == 2'b11) ? ~last_q : nonempty[1];
        issue  = slot_free && (nonempty != 2'b00) && (tag_cnt_q < OUT_MAX);
        pop    = issue ? (grant ? 2'b10 : 2'b01) : 2'b00;
        last_d = issue ? grant : last_q;

        for (int c = 0; c < 2; c++) begin
            push[c]     = req_v[c] && (!full[c] || pop[c]);
            drop_d[c]   = req_v[c] && full[c] && !pop[c];
            wr_ptr_d[c] = push[c] ? wr_ptr_q[c] + 1'b1 : wr_ptr_q[c];
            rd_ptr_d[c] = pop[c]  ? rd_ptr_q[c] + 1'b1 : rd_ptr_q[c];
            case ({push[c], pop[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
                2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
                default: cnt_d[c] = cnt_q[c];
            endcase
        end

        db_valid_d = issue ? 1'b1 : (db_ready ? 1'b0 : db_valid_q);
        db_key_d   = db_key_q;
        db_flag_d  = db_flag_q;
        if (issue) begin
            {db_key_d, db_flag_d} = fifo_mem[grant][rd_ptr_q[grant]];
        end

        tag_pop  = db_rsp_valid && (tag_cnt_q != '0);
        unexp    = db_rsp_valid && (tag_cnt_q == '0);
        tag_wr_d = issue   ? tag_wr_q + 1'b1 : tag_wr_q;
        tag_rd_d = tag_pop ? tag_rd_q + 1'b1 : tag_rd_q;
        case ({issue, tag_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
            2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
            default: tag_cnt_d = tag_cnt_q;
        endcase

        rsp0_d     = tag_pop && !tag_mem[tag_rd_q];
        rsp1_d     = tag_pop &&  tag_mem[tag_rd_q];
        rsp_flag_d = tag_pop ? db_rsp_flag : rsp_flag_q;
        err_d      = err_q | unexp;
    end

    // Storage arrays carry no reset; occupancy counters define what is valid.
    always_ff @(posedge clk156) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                fifo_mem[c][wr_ptr_q[c]] <= req_ent[c];
            end
        end
        if (issue) begin
            tag_mem[tag_wr_q] <= grant;
        end
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            drop_q     <= '0;
            last_q     <= 1'b1;
            db_valid_q <= 1'b0;
            db_key_q   <= '0;
            db_flag_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            tag_cnt_q  <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            rsp_flag_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            drop_q     <= drop_d;
            last_q     <= last_d;
            db_valid_q <= db_valid_d;
            db_key_q   <= db_key_d;
            db_flag_q  <= db_flag_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_cnt_q  <= tag_cnt_d;
            rsp0_q     <= rsp0_d;
            rsp1_q     <= rsp1_d;
            rsp_flag_q <= rsp_flag_d;
            err_q      <= err_d;
        end
    end

    assign db_key     = db_key_q;
    assign db_flag    = db_flag_q;
    assign db_valid   = db_valid_q;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp_flag   = rsp_flag_q;
    assign drop       = drop_q;
    assign err_unexp  = err_q;

`ifdef KV_ARB_STATS_EN
    logic [31:0] st_g0_q, st_g1_q, st_d0_q, st_d1_q;

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            st_g0_q <= '0;
            st_g1_q <= '0;
            st_d0_q <= '0;
            st_d1_q <= '0;
        end else begin
            if (issue && !grant && (st_g0_q != 32'hFFFF_FFFF)) st_g0_q <= st_g0_q + 1'b1;
            if (issue &&  grant && (st_g1_q != 32'hFFFF_FFFF)) st_g1_q <= st_g1_q + 1'b1;
            if (drop_q[0] && (st_d0_q != 32'hFFFF_FFFF))       st_d0_q <= st_d0_q + 1'b1;
            if (drop_q[1] && (st_d1_q != 32'hFFFF_FFFF))       st_d1_q <= st_d1_q + 1'b1;
        end
    end

    assign stat_grant0 = st_g0_q;
    assign stat_grant1 = st_g1_q;
    assign stat_drop0  = st_d0_q;
    assign stat_drop1  = st_d1_q;
`endif

endmodule

// File: tb/tb_kv_req_arbiter.sv
// Scoreboard bench for kv_req_arbiter: expected DB issues and channel replies are queued
// by the stimulus and consumed by a monitor whenever the DUT presents them.
module tb_kv_req_arbiter;

    logic        clk156 = 1'b0;
    logic        eth_rst;
    logic [95:0] req0_key, req1_key;
    logic [3:0]  req0_flag, req1_flag;
    logic        req0_valid, req1_valid;
    logic [95:0] db_key;
    logic [3:0]  db_flag;
    logic        db_valid, db_ready;
    logic        db_rsp_valid;
    logic [3:0]  db_rsp_flag;
    logic        rsp0_valid, rsp1_valid;
    logic [3:0]  rsp_flag;
    logic [1:0]  drop;
    logic        err_unexp;
`ifdef KV_ARB_STATS_EN
    logic [31:0] stat_grant0, stat_grant1, stat_drop0, stat_drop1;
`endif

    kv_req_arbiter dut (
        .clk156(clk156), .eth_rst(eth_rst),
        .req0_key(req0_key), .req0_flag(req0_flag), .req0_valid(req0_valid),
        .req1_key(req1_key), .req1_flag(req1_flag), .req1_valid(req1_valid),
        .db_key(db_key), .db_flag(db_flag), .db_valid(db_valid), .db_ready(db_ready),
        .db_rsp_valid(db_rsp_valid), .db_rsp_flag(db_rsp_flag),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_flag(rsp_flag),
        .drop(drop), .err_unexp(err_unexp)
`ifdef KV_ARB_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
        , .stat_drop0(stat_drop0), .stat_drop1(stat_drop1)
`endif
    );

    always #5 clk156 = ~clk156;

    typedef struct {
        logic [95:0] key;
        logic [3:0]  flag;
    } iss_t;

    typedef struct {
        logic       ch;
        logic [3:0] flag;
    } rsp_t;

    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    iss_t e_i;
    rsp_t e_r;
    int   total = 0;
    int   bad   = 0;
    int   iss_seen   = 0;
    int   drop_seen0 = 0;
    int   drop_seen1 = 0;

    // Monitor: samples on the falling edge, inputs change 1 time unit after the rising edge.
    always @(negedge clk156) begin
        if (!eth_rst) begin
            if (db_valid && db_ready) begin
                iss_seen++;
                total++;
                if (exp_iss.size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected got key=%0h flag=%0h", db_key, db_flag);
                end else begin
                    e_i = exp_iss.pop_front();
                    if (db_key !== e_i.key || db_flag !== e_i.flag) begin
                        bad++;
                        $display("FAIL issue got key=%0h flag=%0h exp key=%0h flag=%0h",
                                 db_key, db_flag, e_i.key, e_i.flag);
                    end
                end
            end
            if (rsp0_valid || rsp1_valid) begin
                total++;
                if (exp_rsp.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected got rsp0=%0b rsp1=%0b flag=%0h",
                             rsp0_valid, rsp1_valid, rsp_flag);
                end else begin
                    e_r = exp_rsp.pop_front();
                    if ((rsp0_valid && rsp1_valid) || rsp1_valid !== e_r.ch || rsp_flag !== e_r.flag) begin
                        bad++;
                        $display("FAIL rsp got rsp0=%0b rsp1=%0b flag=%0h exp ch=%0d flag=%0h",
                                 rsp0_valid, rsp1_valid, rsp_flag, e_r.ch, e_r.flag);
                    end
                end
            end
            if (drop[0]) drop_seen0++;
            if (drop[1]) drop_seen1++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk156);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        eth_rst      = 1'b1;
        req0_valid   = 1'b0;
        req1_valid   = 1'b0;
        db_rsp_valid = 1'b0;
        exp_iss.delete();
        exp_rsp.delete();
        tick(2);
        eth_rst    = 1'b0;
        iss_seen   = 0;
        drop_seen0 = 0;
        drop_seen1 = 0;
    endtask

    task automatic pulse(input bit v0, input logic [95:0] k0, input logic [3:0] f0,
                         input bit v1, input logic [95:0] k1, input logic [3:0] f1);
        req0_valid = v0; req0_key = k0; req0_flag = f0;
        req1_valid = v1; req1_key = k1; req1_flag = f1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic reply(input logic [3:0] f);
        db_rsp_valid = 1'b1;
        db_rsp_flag  = f;
        tick();
        db_rsp_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while ((exp_iss.size() != 0 || exp_rsp.size() != 0) && n < max) begin
            tick();
            n++;
        end
        chk(name, 128'(exp_iss.size() + exp_rsp.size()), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        eth_rst = 1'b1;
        req0_key = '0; req1_key = '0; req0_flag = '0; req1_flag = '0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        db_ready = 1'b0; db_rsp_valid = 1'b0; db_rsp_flag = '0;
        tick(3);
        chk("rst_db_valid", db_valid, 0);
        chk("rst_db_key", db_key, 0);
        chk("rst_db_flag", db_flag, 0);
        chk("rst_rsp", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_rsp_flag", rsp_flag, 0);
        chk("rst_drop", drop, 0);
        chk("rst_err", err_unexp, 0);

        // Single request and its reply
        do_reset();
        db_ready = 1'b1;
        exp_iss.push_back('{96'hA, 4'h3});
        pulse(1, 96'hA, 4'h3, 0, 96'h0, 4'h0);
        chk("t1_no_bypass", db_valid, 0);
        tick();
        chk("t1_db_valid", db_valid, 1);
        chk("t1_db_key", db_key, 96'hA);
        tick();
        exp_rsp.push_back('{1'b0, 4'h4});
        reply(4'h4);
        chk("t1_rsp0", rsp0_valid, 1);
        chk("t1_rsp_flag", rsp_flag, 4'h4);
        tick();
        chk("t1_rsp_flag_hold", {rsp0_valid, rsp_flag}, {1'b0, 4'h4});
        drain("t1_drain", 10);

        // Contention: alternating grants starting with ch0
        do_reset();
        db_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_iss.push_back('{96'h100 + 96'(i), 4'(i)});
            exp_iss.push_back('{96'h200 + 96'(i), 4'(i + 8)});
        end
        for (int i = 0; i < 4; i++) begin
            pulse(1, 96'h100 + 96'(i), 4'(i), 1, 96'h200 + 96'(i), 4'(i + 8));
        end
        drain("t2_drain", 40);
        chk("t2_no_drops", 128'(drop_seen0 + drop_seen1), 0);
        chk("t2_issued", 128'(iss_seen), 8);

        // Overflow: output register already holds a request, 5 pulses into a depth-4 FIFO
        do_reset();
        db_ready = 1'b0;
        exp_iss.push_back('{96'h300, 4'h1});
        pulse(0, 96'h0, 4'h0, 1, 96'h300, 4'h1);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_iss.push_back('{96'h310 + 96'(i), 4'(i)});
            pulse(0, 96'h0, 4'h0, 1, 96'h310 + 96'(i), 4'(i));
            if (i == 3) chk("t3_no_drop_4th", drop, 2'b00);
        end
        chk("t3_drop_5th", drop, 2'b10);
        tick();
        chk("t3_drop_one_cycle", drop, 2'b00);
        db_ready = 1'b1;
        drain("t3_drain", 40);
        chk("t3_drop_count", 128'({drop_seen1[7:0], drop_seen0[7:0]}), 128'h0100);

        // Outstanding limit
        do_reset();
        db_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_iss.push_back('{96'h400 + 96'(i), 4'(i)});
            exp_iss.push_back('{96'h500 + 96'(i), 4'(i + 5)});
        end
        for (int i = 0; i < 5; i++) begin
            pulse(1, 96'h400 + 96'(i), 4'(i), 1, 96'h500 + 96'(i), 4'(i + 5));
        end
        tick(10);
        chk("t4_stall_count", 128'(iss_seen), 8);
        chk("t4_stall_valid", db_valid, 0);
        exp_rsp.push_back('{1'b0, 4'h5});
        reply(4'h5);
        tick(8);
        chk("t4_one_more", 128'(iss_seen), 9);
        chk("t4_valid_low", db_valid, 0);
        chk("t4_left", 128'(exp_iss.size()), 1);

        // Reply routing and unexpected reply
        do_reset();
        db_ready = 1'b1;
        exp_iss.push_back('{96'h601, 4'h0});
        exp_iss.push_back('{96'h602, 4'h0});
        exp_iss.push_back('{96'h603, 4'h0});
        pulse(0, 96'h0, 4'h0, 1, 96'h601, 4'h0);
        pulse(1, 96'h602, 4'h0, 0, 96'h0, 4'h0);
        pulse(0, 96'h0, 4'h0, 1, 96'h603, 4'h0);
        tick(4);
        exp_rsp.push_back('{1'b1, 4'h1});
        exp_rsp.push_back('{1'b0, 4'h2});
        exp_rsp.push_back('{1'b1, 4'h3});
        reply(4'h1);
        reply(4'h2);
        reply(4'h3);
        tick();
        chk("t5_err_before", err_unexp, 0);
        reply(4'h7);
        chk("t5_err_set", err_unexp, 1);
        chk("t5_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        tick();
        chk("t5_err_sticky", err_unexp, 1);
        chk("t5_flag_kept", rsp_flag, 4'h3);
        drain("t5_drain", 10);

        // Reset mid-run with db_valid pending and three outstanding
        do_reset();
        db_ready = 1'b1;
        exp_iss.push_back('{96'h700, 4'h1});
        exp_iss.push_back('{96'h701, 4'h2});
        pulse(1, 96'h700, 4'h1, 0, 96'h0, 4'h0);
        pulse(1, 96'h701, 4'h2, 0, 96'h0, 4'h0);
        pulse(1, 96'h702, 4'h3, 0, 96'h0, 4'h0);
        tick();
        db_ready = 1'b0;
        chk("t6_pending", {db_valid, db_key}, {1'b1, 96'h702});
        chk("t6_issued_before", 128'(iss_seen), 2);
        eth_rst = 1'b1;
        exp_iss.delete();
        tick();
        chk("t6_rst_db", {db_valid, db_key, db_flag}, 0);
        chk("t6_rst_misc", {rsp1_valid, rsp0_valid, rsp_flag, drop, err_unexp}, 0);
        eth_rst = 1'b0;
        tick();
        reply(4'h9);
        chk("t6_err_after", err_unexp, 1);
        chk("t6_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        tick(3);
        chk("t6_still_idle", db_valid, 0);

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
